// File: rtl/sbox_table_writer.sv
// rtl/sbox_table_writer.sv - rewrites the masked S-box table from the unmasked source ROM; optional double buffering via SBOX_TABLE_DOUBLE_BUFFER_EN
module sbox_table_writer #(
    parameter int SRC_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] m_in,
    input  logic [7:0] m_out,
    output logic [9:0] src_addr,
    input  logic [7:0] src_data,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       busy,
    output logic       done,
    output logic       active_page
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // DRAIN lasts SRC_LATENCY+1 cycles so the final read reaches the write register
    localparam logic [1:0] DRAIN_LAST = 2'(SRC_LATENCY);

    logic [1:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] m_in_q, m_in_d;
    logic [7:0] m_out_q, m_out_d;
    logic       ap_q, ap_d;

    logic [SRC_LATENCY-1:0] dl_vld_q, dl_vld_d;
    logic [7:0]             dl_idx_q [SRC_LATENCY];
    logic [7:0]             dl_idx_d [SRC_LATENCY];

    logic [9:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;

    logic       page;
    logic       aligned_vld;
    logic [7:0] aligned_idx;

    assign aligned_vld = dl_vld_q[SRC_LATENCY-1];
    assign aligned_idx = dl_idx_q[SRC_LATENCY-1];

    // Run sequencing: accept start only when idle, sweep 256 indices, then drain the ROM pipe
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        m_in_d  = m_in_q;
        m_out_d = m_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    idx_d   = 8'd0;
                    m_in_d  = m_in;
                    m_out_d = m_out;
                end
            end
            S_FILL: begin
                if (idx_q == 8'hFF) begin
                    state_d = S_DRAIN;
                    idx_d   = 8'd0;
                    cnt_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_FINISH;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Page selection: new table goes to the page readers are not using, swapped as the run completes
    always_comb begin
`ifdef SBOX_TABLE_DOUBLE_BUFFER_EN
        page = ~ap_q;
        ap_d = ap_q ^ ((state_q == S_DRAIN) && (cnt_q == DRAIN_LAST));
`else
        page = 1'b0;
        ap_d = 1'b0;
`endif
    end

    // Delay line carrying the issued index alongside the ROM read latency
    always_comb begin
        dl_vld_d    = '0;
        dl_idx_d    = dl_idx_q;
        dl_vld_d[0] = (state_q == S_FILL);
        dl_idx_d[0] = idx_q;
        for (int k = 1; k < SRC_LATENCY; k++) begin
            dl_vld_d[k] = dl_vld_q[k-1];
            dl_idx_d[k] = dl_idx_q[k-1];
        end
    end

    // Registered write port: masked address/data when a read lands, all zero otherwise
    always_comb begin
        wr_en_d   = aligned_vld;
        wr_addr_d = 10'd0;
        wr_data_d = 8'd0;
        if (aligned_vld) begin
            wr_addr_d = {1'b0, page, aligned_idx ^ m_in_q};
            wr_data_d = src_data ^ m_out_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'd0;
            cnt_q     <= 2'd0;
            m_in_q    <= 8'd0;
            m_out_q   <= 8'd0;
            ap_q      <= 1'b0;
            dl_vld_q  <= '0;
            for (int k = 0; k < SRC_LATENCY; k++) begin
                dl_idx_q[k] <= 8'd0;
            end
            wr_en_q   <= 1'b0;
            wr_addr_q <= 10'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            m_in_q    <= m_in_d;
            m_out_q   <= m_out_d;
            ap_q      <= ap_d;
            dl_vld_q  <= dl_vld_d;
            dl_idx_q  <= dl_idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign src_addr    = (state_q == S_FILL) ? {2'b00, idx_q} : 10'd0;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign active_page = ap_q;

endmodule

// File: tb/tb_sbox_table_writer.sv
// tb/tb_sbox_table_writer.sv - directed bench for sbox_table_writer with an AES S-box source ROM model
module tb_sbox_table_writer;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] m_in;
    logic [7:0] m_out;
    logic [9:0] src_addr;
    logic [7:0] src_data;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       busy;
    logic       done;
    logic       active_page;
    logic [7:0] rom_p1;

    int n_pass  = 0;
    int n_total = 0;
    logic exp_ap = 1'b0;
    logic [7:0] got [256];

    sbox_table_writer #(.SRC_LATENCY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .m_in        (m_in),
        .m_out       (m_out),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .busy        (busy),
        .done        (done),
        .active_page (active_page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // two-cycle source ROM
    always @(posedge clk) begin
        rom_p1   <= SBOX[src_addr[7:0]];
        src_data <= rom_p1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // one run; restart_at>0 re-asserts start with new masks, rst_at>0 aborts the run
    task automatic do_run(input logic [7:0] mi, input logic [7:0] mo,
                          input int restart_at, input int rst_at);
        int   hits [256];
        int   n_wr, first_wr, last_wr, n_done, done_cyc;
        int   e_data, e_addr, e_busy, e_src, e_zero, e_ap, e_hit;
        int   last_busy;
        logic pg, ap_new;
        logic exp_wr;
        int   i;
        n_wr = 0; first_wr = -1; last_wr = -1; n_done = 0; done_cyc = -1;
        e_data = 0; e_addr = 0; e_busy = 0; e_src = 0; e_zero = 0; e_ap = 0; e_hit = 0;
        for (int k = 0; k < 256; k++) begin hits[k] = 0; got[k] = 8'h00; end
`ifdef SBOX_TABLE_DOUBLE_BUFFER_EN
        pg = ~exp_ap;
        ap_new = ~exp_ap;
`else
        pg = 1'b0;
        ap_new = 1'b0;
`endif
        last_busy = (rst_at > 0) ? rst_at : 260;
        @(negedge clk);
        start = 1'b1; m_in = mi; m_out = mo;
        for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            exp_wr = (c >= 4 && c <= 259 && (rst_at == 0 || c <= rst_at));
            i = c - 4;
            if (wr_en !== exp_wr) e_addr++;
            if (wr_en) begin
                n_wr++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                hits[wr_addr[7:0]]++;
                got[wr_addr[7:0]] = wr_data;
                if (exp_wr) begin
                    if (wr_addr !== {1'b0, pg, 8'(i) ^ mi}) e_addr++;
                    if (wr_data !== (SBOX[i] ^ mo)) e_data++;
                end
            end else if (wr_addr !== 10'd0 || wr_data !== 8'd0) e_zero++;
            if (c >= 1 && c <= 256 && (rst_at == 0 || c <= rst_at)) begin
                if (src_addr !== 10'(c - 1)) e_src++;
            end else if (src_addr !== 10'd0) e_src++;
            if (busy !== (c <= last_busy)) e_busy++;
            if (done) begin n_done++; done_cyc = c; end
            if (rst_at == 0 && c >= 260) begin
                if (active_page !== ap_new) e_ap++;
            end else if (active_page !== exp_ap) e_ap++;
            if (c == rst_at + 1 && rst_at > 0) begin
                check("abort_wr_en", wr_en, 0);
                check("abort_busy", busy, 0);
            end
            start = 1'b0;
            rst   = (c == rst_at);
            if (c == restart_at) begin
                start = 1'b1; m_in = ~mi; m_out = mo ^ 8'h5A;
            end
        end
        check("wr_seq_err", e_addr, 0);
        check("wr_data_err", e_data, 0);
        check("idle_zero_err", e_zero, 0);
        check("src_addr_err", e_src, 0);
        check("busy_err", e_busy, 0);
        check("active_page_err", e_ap, 0);
        if (rst_at > 0) begin
            check("abort_done_cnt", n_done, 0);
            check("abort_ap", active_page, 0);
            exp_ap = 1'b0;
        end else begin
            for (int k = 0; k < 256; k++) if (hits[k] != 1) e_hit++;
            check("write_count", n_wr, 256);
            check("addr_cover_err", e_hit, 0);
            check("first_wr_cycle", first_wr, 4);
            check("last_wr_cycle", last_wr, 259);
            check("done_count", n_done, 1);
            check("done_cycle", done_cyc, 260);
            exp_ap = ap_new;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_in = 8'h00; m_out = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_src_addr", src_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_active_page", active_page, 0);

        do_run(8'h00, 8'h00, 0, 0);
        check("copy_0x00", got[8'h00], 8'h63);
        check("copy_0x53", got[8'h53], 8'hED);

        do_run(8'h53, 8'hA5, 0, 0);
        check("mask_addr53", got[8'h53], 8'hC6);
        check("mask_addr00", got[8'h00], 8'h48);

        do_run(8'h11, 8'h22, 0, 100);
        repeat (5) @(negedge clk);
        check("post_abort_done", done, 0);
        check("post_abort_ap", active_page, 0);

        do_run(8'h11, 8'h22, 0, 0);
        check("clean_addr11", got[8'h11], 8'h63 ^ 8'h22);

        do_run(8'h3C, 8'h81, 50, 0);
        check("restart_addr3c", got[8'h3C], 8'h63 ^ 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
